// File: rtl/reset_pkg.sv
// Shared types and width helpers for the reset sequencer slice.
package reset_pkg;

  // Sequencer states; 2-bit encoding.
  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } rst_state_e;

  // Bits needed to hold the value n itself (never less than 1).
  function automatic int unsigned clog2p1(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Multi-flop synchroniser for one asynchronous level; the synchronous
// reset clears every stage so the output reads "not ok" until refilled.
module bit_synchronizer #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input in at bit 0; the oldest sample leaves at the top.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Stage registers with pessimistic synchronous clear.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Per-domain reset sequencer: merges all reset sources into one fault,
// asserts every channel at once and releases them in staggered order.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned CHANNELS       = 3,
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned FILTER_CYCLES  = 16,
  parameter int unsigned HOLD_CYCLES    = 20,
  parameter int unsigned STAGGER_CYCLES = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                ext_reset_n_i,
  input  logic                lock_i,
  input  logic                sw_reset_i,
  output logic [CHANNELS-1:0] reset_n_o,
  output logic                ready_o
);

  localparam int unsigned LCK_W = clog2p1(FILTER_CYCLES);
  localparam int unsigned CNT_W = clog2p1(max2(HOLD_CYCLES, STAGGER_CYCLES));
  localparam int unsigned IDX_W = clog2p1(CHANNELS);

  localparam logic [LCK_W-1:0] LCK_MAX   = LCK_W'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CHANNELS - 1);

  logic ext_ok;
  logic lock_sync;
  logic lock_good;
  logic fault;

  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;

  rst_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CHANNELS-1:0] rst_n_q, rst_n_d;
  logic               ready_q, ready_d;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (ext_reset_n_i),
    .q_o     (ext_ok)
  );

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (lock_i),
    .q_o     (lock_sync)
  );

  // Lock filter: count consecutive synchronised-high cycles, saturating;
  // a single low cycle clears the count and drops lock_good immediately.
  always_comb begin
    lock_cnt_d = '0;
    if (lock_sync) begin
      lock_cnt_d = (lock_cnt_q == LCK_MAX) ? lock_cnt_q : lock_cnt_q + LCK_W'(1);
    end
    lock_good = lock_sync & (lock_cnt_q == LCK_MAX);
  end

  // Any source holding reset forces the whole domain back to ASSERT.
  always_comb begin
    fault = reset_i | sw_reset_i | ~ext_ok | ~lock_good;
  end

  // Next-state and registered-output logic of the release sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    if (fault) begin
      state_d = ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        ASSERT: begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
        HOLD: begin
          if (cnt_q == '0) begin
            rst_n_d[0] = 1'b1;
            if (CHANNELS == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
              idx_d   = IDX_W'(1);
              cnt_d   = STAG_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == '0) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
              if (idx_q == IDX_W'(i)) begin
                rst_n_d[i] = 1'b1;
              end
            end
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              cnt_d = STAG_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RUN: begin
          rst_n_d = '1;
          ready_d = 1'b1;
        end
        default: begin
          state_d = ASSERT;
          rst_n_d = '0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  // State, counters, filter and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_n_q    <= '0;
      ready_q    <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_n_q    <= rst_n_d;
      ready_q    <= ready_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign reset_n_o = rst_n_q;
  assign ready_o   = ready_q;

endmodule
